bus_lane_arbiter: RTL and testbench

//  Round-robin arbiter for the shared 16-bit tristate bus_driver datapath.

---
 rtl/bus_lane_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_lane_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_lane_arbiter.sv
// Round-robin arbiter for the shared 16-bit bus_driver datapath. Grants one requester
// at a time with its byte-lane enables, caps tenure length and inserts idle turnaround.
module bus_lane_arbiter #(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 8,
   parameter int TURN_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [2*NREQ-1:0] lanes,
   output logic [NREQ-1:0]   gnt,
   output logic [2:0]        owner,
   output logic              enh,
   output logic              enl,
   output logic              busy,
   output logic              timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t          state, state_d;
   logic [NREQ-1:0] gnt_d;
   logic [2:0]      owner_d, rr_ptr, rr_ptr_d, turn_cnt, turn_cnt_d;
   logic [7:0]      hold_cnt, hold_cnt_d;
   logic            enh_d, enl_d, busy_d, timeout_d;

   // Requester views padded to 8 entries so a 3-bit index always selects in range.
   logic [7:0] elig8, req8;
   logic [1:0] pair8 [8];

   for (genvar g = 0; g < 8; g++) begin : g_pad
      if (g < NREQ) begin : g_real
         assign req8[g]  = req[g];
         assign pair8[g] = lanes[2*g +: 2];
         assign elig8[g] = req[g] & (|lanes[2*g +: 2]);
      end else begin : g_none
         assign req8[g]  = 1'b0;
         assign pair8[g] = 2'b00;
         assign elig8[g] = 1'b0;
      end
   end

   logic       pick_vld, owner_req, at_max;
   logic [2:0] pick_idx, scan_idx;
   logic [1:0] pick_lanes;

   // First eligible requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      pick_vld   = 1'b0;
      pick_idx   = 3'd0;
      pick_lanes = 2'b00;
      scan_idx   = 3'd0;
      for (int k = 0; k < NREQ; k++) begin
         scan_idx = 3'((int'(rr_ptr) + k) % NREQ);
         if (!pick_vld && elig8[scan_idx]) begin
            pick_vld   = 1'b1;
            pick_idx   = scan_idx;
            pick_lanes = pair8[scan_idx];
         end
      end
   end

   assign owner_req = req8[owner];
   assign at_max    = (hold_cnt == 8'(MAX_HOLD));

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a
      // signal unassigned and no latch is inferred.
      state_d    = state;
      gnt_d      = gnt;
      owner_d    = owner;
      enh_d      = enh;
      enl_d      = enl;
      busy_d     = busy;
      timeout_d  = 1'b0;
      rr_ptr_d   = rr_ptr;
      hold_cnt_d = hold_cnt;
      turn_cnt_d = turn_cnt;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_d      = GRANT;
               gnt_d        = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
               owner_d      = pick_idx;
               {enh_d, enl_d} = pick_lanes;
               busy_d       = 1'b1;
               rr_ptr_d     = 3'((int'(pick_idx) + 1) % NREQ);
               hold_cnt_d   = 8'd1;
            end
         end
         GRANT: begin
            if (!owner_req || at_max) begin
               state_d    = TURN;
               gnt_d      = '0;
               enh_d      = 1'b0;
               enl_d      = 1'b0;
               busy_d     = 1'b0;
               // A voluntary release on the same cycle as the cap is not a timeout.
               timeout_d  = owner_req & at_max;
               turn_cnt_d = 3'd1;
            end else begin
               hold_cnt_d = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            end
         end
         TURN: begin
            if (turn_cnt >= 3'(TURN_CYC)) state_d = IDLE;
            else                          turn_cnt_d = turn_cnt + 3'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= 3'd0;
         enh      <= 1'b0;
         enl      <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         rr_ptr   <= 3'd0;
         hold_cnt <= 8'd0;
         turn_cnt <= 3'd0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         owner    <= owner_d;
         enh      <= enh_d;
         enl      <= enl_d;
         busy     <= busy_d;
         timeout  <= timeout_d;
         rr_ptr   <= rr_ptr_d;
         hold_cnt <= hold_cnt_d;
         turn_cnt <= turn_cnt_d;
      end
   end

endmodule

// File: tb/tb_bus_lane_arbiter.sv
// Self-checking bench for bus_lane_arbiter: vector table, directed multi-cycle
// sequences and randomized traffic against a tenure-level reference model.
module tb_bus_lane_arbiter;

   localparam int NREQ     = 4;
   localparam int MAX_HOLD = 8;
   localparam int TURN_CYC = 1;
   localparam int PERIOD   = MAX_HOLD + TURN_CYC + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'h0;
   logic [7:0] lanes = 8'h00;
   logic [3:0] gnt;
   logic [2:0] owner;
   logic       enh, enl, busy, timeout;

   int checks   = 0;
   int failures = 0;

   bus_lane_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD), .TURN_CYC(TURN_CYC)) dut (
      .clk(clk), .rst(rst), .req(req), .lanes(lanes), .gnt(gnt), .owner(owner),
      .enh(enh), .enl(enl), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Owner only carries meaning while busy, so it is masked otherwise.
   function automatic logic [10:0] pack(input logic [3:0] g, input logic [2:0] o,
                                        input logic h, input logic l,
                                        input logic b, input logic t);
      return {g, (b ? o : 3'd0), h, l, b, t};
   endfunction

   function automatic logic [10:0] dut_vec();
      return pack(gnt, owner, enh, enl, busy, timeout);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'h0; lanes = 8'h00;
      step();
      rst = 1'b0;
   endtask

   // Reference model: one tenure at a time, described by who owns the bus,
   // how long they have held it and how much turnaround is still owed.
   int         m_owner, m_len, m_cool, m_ptr;
   logic       m_to;
   logic [1:0] m_lanes;

   task automatic model_step(input logic r_rst, input logic [3:0] r, input logic [7:0] l);
      logic [3:0] rb;
      logic [7:0] lb;
      bit         found;
      m_to = 1'b0;
      if (r_rst) begin
         m_owner = -1; m_len = 0; m_cool = 0; m_ptr = 0; m_lanes = 2'b00;
      end else if (m_owner >= 0) begin
         rb = r >> m_owner;
         if (!rb[0] || m_len == MAX_HOLD) begin
            m_to    = rb[0] && (m_len == MAX_HOLD);
            m_owner = -1;
            m_cool  = TURN_CYC;
         end else begin
            m_len++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         found = 0;
         for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            rb  = r >> idx;
            lb  = l >> (2 * idx);
            if (!found && rb[0] && lb[1:0] != 2'b00) begin
               found   = 1;
               m_owner = idx;
               m_len   = 1;
               m_lanes = lb[1:0];
               m_ptr   = (idx + 1) % NREQ;
            end
         end
      end
   endtask

   function automatic logic [10:0] model_vec();
      logic b;
      b = (m_owner >= 0);
      return pack(b ? 4'(1 << m_owner) : 4'd0, b ? 3'(m_owner) : 3'd0,
                  b & m_lanes[1], b & m_lanes[0], b, m_to);
   endfunction

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [7:0] lanes;
      logic [3:0] g;
      logic [2:0] o;
      logic       h, l, b, t;
   } vec_t;

   vec_t tbl [10];

   initial begin
      // Reset hold, first grant, reset, lane-mask tenure, masked requester.
      tbl[0] = '{1'b1, 4'hF,    8'hFF, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 4'hF,    8'hFF, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b0, 4'hF,    8'hFF, 4'b0001, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 4'h0,    8'h00, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 4'b0100, 8'h20, 4'b0100, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 4'b0100, 8'h10, 4'b0100, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 4'b0100, 8'h10, 4'b0100, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 4'b0000, 8'h10, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 4'b0011, 8'h0C, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[9] = '{1'b0, 4'b0011, 8'h0C, 4'b0010, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};

      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].rst; req = tbl[i].req; lanes = tbl[i].lanes;
         step();
         check($sformatf("table_row%0d", i), dut_vec(),
               pack(tbl[i].g, tbl[i].o, tbl[i].h, tbl[i].l, tbl[i].b, tbl[i].t));
      end

      // Round robin under full load: fixed tenure, timeout pulse, turnaround gap.
      do_reset();
      req = 4'hF; lanes = 8'hFF;
      for (int c = 0; c < 5 * PERIOD; c++) begin
         int w, ten;
         logic on;
         step();
         w   = c % PERIOD;
         ten = c / PERIOD;
         on  = (w < MAX_HOLD);
         check($sformatf("rr_cycle%0d", c), dut_vec(),
               pack(on ? 4'(1 << (ten % NREQ)) : 4'd0, 3'(ten % NREQ), on, on, on,
                    w == MAX_HOLD));
      end

      // Voluntary release after 3 GRANT cycles, then req0 raised during TURN.
      do_reset();
      req = 4'b0010; lanes = 8'hFF;
      step(); check("vol_grant",   dut_vec(), pack(4'b0010, 3'd1, 1, 1, 1, 0));
      step(); check("vol_hold2",   dut_vec(), pack(4'b0010, 3'd1, 1, 1, 1, 0));
      step(); check("vol_hold3",   dut_vec(), pack(4'b0010, 3'd1, 1, 1, 1, 0));
      req = 4'b0000;
      step(); check("vol_release", dut_vec(), pack(4'b0000, 3'd0, 0, 0, 0, 0));
      req = 4'b0001;
      for (int k = 0; k < TURN_CYC; k++) begin
         step(); check($sformatf("vol_turn%0d", k), dut_vec(), pack(4'b0000, 3'd0, 0, 0, 0, 0));
      end
      step(); check("vol_next_grant", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));

      // Release on the very cycle the hold cap is reached: no timeout.
      do_reset();
      req = 4'b0001; lanes = 8'hFF;
      step(); check("sim_grant", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));
      repeat (MAX_HOLD - 1) step();
      check("sim_last_cycle", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));
      req = 4'b0000;
      step(); check("sim_release", dut_vec(), pack(4'b0000, 3'd0, 0, 0, 0, 0));
      step(); check("sim_turn",    dut_vec(), pack(4'b0000, 3'd0, 0, 0, 0, 0));

      // Reset in the 4th GRANT cycle: everything drops, pointer back to 0.
      do_reset();
      req = 4'hF; lanes = 8'hFF;
      step(); check("rstmid_grant", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));
      repeat (3) step();
      check("rstmid_cycle4", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));
      rst = 1'b1;
      step(); check("rstmid_drop", dut_vec(), pack(4'b0000, 3'd0, 0, 0, 0, 0));
      rst = 1'b0;
      step(); check("rstmid_regrant", dut_vec(), pack(4'b0001, 3'd0, 1, 1, 1, 0));

      // Randomized traffic against the reference model plus invariants.
      do_reset();
      model_step(1'b1, 4'h0, 8'h00);
      req = 4'hF;
      for (int n = 0; n < 800; n++) begin
         rst = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 5) == 0) req = 4'($urandom);
         lanes = 8'($urandom);
         step();
         model_step(rst, req, lanes);
         check($sformatf("rand_%0d", n), dut_vec(), model_vec());
         check($sformatf("rand_onehot_%0d", n), 32'($onehot0(gnt)), 32'd1);
         check($sformatf("rand_en_busy_%0d", n), 32'((enh | enl) & ~busy), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
